// File: rtl/simd_matmul_engine.sv
// NxN signed matrix multiply-accumulate engine, N*N MAC lanes over k.
// Ports: CLK/reset, enable, in_valid/in_ready, acc_mode, mat_a, mat_b,
//   out_valid/out_ready, mat_c, overflow, busy.
module simd_matmul_engine #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int OW = 32
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                acc_mode,
  input  logic [N*N*DW-1:0]   mat_a,
  input  logic [N*N*DW-1:0]   mat_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*N*OW-1:0]   mat_c,
  output logic                overflow,
  output logic                busy
);

  localparam int AW = 2*DW + $clog2(N) + 1;
  localparam int KW = $clog2(N);
  localparam int NE = N*N;
  localparam logic [KW-1:0] KLAST = KW'(N-1);
  localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MINV = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t            state_q;
  logic [KW-1:0]     k_q;
  logic [NE*DW-1:0]  a_q;
  logic [NE*DW-1:0]  b_q;
  logic [NE*OW-1:0]  c_q;
  logic              ovf_q;
  logic signed [AW-1:0] acc_q [NE];
  logic signed [AW-1:0] acc_d [NE];
  logic signed [AW-1:0] c_ext [NE];
  logic [NE*OW-1:0]  c_sat;
  logic [NE-1:0]     sat;
  logic              accept;

  assign in_ready  = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == COMPUTE);
  assign mat_c     = c_q;
  assign overflow  = ovf_q;

  // Lane e = j*N+i matches the slot order of mat_c.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int E = j*N + i;
      logic signed [DW-1:0]   ae;
      logic signed [DW-1:0]   be;
      logic signed [2*DW-1:0] prod;
      logic [AW-OW:0]         hi;
      logic [OW-1:0]          ce;

      assign ae   = a_q[(NE-1-i*N-int'(k_q))*DW +: DW];
      assign be   = b_q[(NE-1-j*N-int'(k_q))*DW +: DW];
      assign prod = ae * be;
      assign acc_d[E] = acc_q[E] +
        {{(AW-2*DW){prod[2*DW-1]}}, prod};

      // Fits in OW bits iff the top AW-OW+1 bits agree.
      assign hi     = acc_d[E][AW-1:OW-1];
      assign sat[E] = ~((&hi) | (~|hi));
      assign c_sat[(NE-1-E)*OW +: OW] =
        sat[E] ? (acc_d[E][AW-1] ? MINV : MAXV)
               : acc_d[E][OW-1:0];

      assign ce       = c_q[(NE-1-E)*OW +: OW];
      assign c_ext[E] = {{(AW-OW){ce[OW-1]}}, ce};
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      for (int e = 0; e < NE; e++) acc_q[e] <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // Accept from DONE is the hand-off; c_q is still
          // the result being handed off this edge.
          if (accept) begin
            a_q     <= mat_a;
            b_q     <= mat_b;
            k_q     <= '0;
            state_q <= COMPUTE;
            for (int e = 0; e < NE; e++)
              acc_q[e] <= acc_mode ? c_ext[e] : '0;
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        COMPUTE: begin
          if (enable) begin
            for (int e = 0; e < NE; e++) acc_q[e] <= acc_d[e];
            if (k_q == KLAST) begin
              k_q     <= '0;
              c_q     <= c_sat;
              ovf_q   <= |sat;
              state_q <= DONE;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_matmul_engine.sv
// Scoreboard bench for simd_matmul_engine, N=4, DW=OW=32.
// Driver pushes expected results; monitor pops at each hand-off.
module tb_simd_matmul_engine;

  localparam int N = 4;
  localparam int W = N*N*32;

  logic         CLK;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic         acc_mode;
  logic [W-1:0] mat_a;
  logic [W-1:0] mat_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] mat_c;
  logic         overflow;
  logic         busy;

  simd_matmul_engine dut (
    .CLK       (CLK),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_mode  (acc_mode),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mat_c     (mat_c),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] c;
    logic         ovf;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   seen     = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // A(i,k) at slot i*N+k, B(k,j) at slot j*N+k, C(i,j) at slot j*N+i.
  function automatic logic [W-1:0] fill(logic [31:0] v);
    logic [W-1:0] r;
    for (int s = 0; s < N*N; s++) r[s*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] a_ident();
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        r[(15-(i*N+k))*32 +: 32] = (i == k) ? 32'd1 : 32'd0;
    return r;
  endfunction

  // A(i,k) = i+1 for k=0, else 0.
  function automatic logic [W-1:0] a_col0();
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++)
      r[(15-(i*N))*32 +: 32] = 32'(i + 1);
    return r;
  endfunction

  function automatic logic [W-1:0] b_tens();
    logic [W-1:0] r = '0;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++)
        r[(15-(j*N+k))*32 +: 32] = 32'(10*k + j);
    return r;
  endfunction

  // mode 0: s*(10i+j); mode 1: (i+1)*j
  function automatic logic [W-1:0] c_exp(int mode, int s);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(15-(j*N+i))*32 +: 32] =
          (mode == 0) ? 32'(s*(10*i + j)) : 32'((i + 1)*j);
    return r;
  endfunction

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b,
                       logic m, logic ordy, logic [W-1:0] ec,
                       logic eo, int lat);
    exp_t e;
    bit   got = 0;
    @(negedge CLK);
    mat_a     = a;
    mat_b     = b;
    acc_mode  = m;
    out_ready = ordy;
    in_valid  = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      #1;
      if (in_ready) got = 1;
      else @(negedge CLK);
    end
    if (!got) begin
      fail_now("accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    e.c = ec;
    e.ovf = eo;
    e.lat = lat;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge CLK);
      #3;
      if (exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin
      fail_now(nm);
      exp_q.delete();
      seen = 0;
    end
  endtask

  // Monitor: samples 2ns after the falling edge, after the driver.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (reset && out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out actual=valid required=idle");
        end else begin
          e = exp_q[0];
          if (!seen) begin
            chk("latency", W'(cyc - e.acc_cyc), W'(e.lat));
            seen = 1;
          end
          if (out_ready) begin
            chk("mat_c", mat_c, e.c);
            chk("overflow", W'(overflow), W'(e.ovf));
            void'(exp_q.pop_front());
            seen = 0;
          end else begin
            chk("hold_mat_c", mat_c, e.c);
            chk("hold_in_ready", W'(in_ready), W'(0));
          end
        end
      end
    end
  end

  initial begin
    bit got;
    reset     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    acc_mode  = 1'b0;
    mat_a     = '0;
    mat_b     = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_mat_c", mat_c, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_overflow", W'(overflow), W'(0));
    @(negedge CLK);
    #3 reset = 1'b1;
    #1 chk("rst_in_ready", W'(in_ready), W'(1));

    // Identity overwrite
    issue(a_ident(), b_tens(), 0, 1, c_exp(0, 1), 0, 4);
    drain("case1");
    chk("c00_msb", W'(mat_c[511:480]), W'(0));

    // Accumulate onto held result
    issue(a_ident(), b_tens(), 1, 1, c_exp(0, 2), 0, 4);
    drain("case2");
    chk("c33_66", W'(mat_c[31:0]), W'(66));

    // Non-identity A distinguishes row/column packing
    issue(a_col0(), b_tens(), 0, 1, c_exp(1, 0), 0, 4);
    drain("col0");

    // Saturation both directions
    issue(fill(32'h7FFFFFFF), fill(32'h7FFFFFFF), 0, 1,
          fill(32'h7FFFFFFF), 1, 4);
    issue(fill(32'h80000000), fill(32'h7FFFFFFF), 0, 1,
          fill(32'h80000000), 1, 4);
    drain("sat");

    // Stall 3 cycles after the 2nd MAC
    issue(a_ident(), b_tens(), 0, 1, c_exp(0, 1), 0, 7);
    repeat (3) @(negedge CLK);
    enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge CLK);
      #1 chk("stall_busy", W'(busy), W'(1));
    end
    enable = 1'b1;
    drain("stall");

    // Backpressure, then hand-off with accumulate in one edge
    issue(a_ident(), b_tens(), 0, 0, c_exp(0, 1), 0, 4);
    got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge CLK);
      #3;
      if (out_valid) got = 1;
    end
    if (!got) fail_now("bp_wait");
    repeat (5) @(negedge CLK);
    issue(a_ident(), b_tens(), 1, 1, c_exp(0, 2), 0, 4);
    drain("b2b");

    // Async reset at k=2
    issue(a_ident(), b_tens(), 0, 1, c_exp(0, 1), 0, 4);
    repeat (3) @(negedge CLK);
    #3 reset = 1'b0;
    #1;
    chk("ar_out_valid", W'(out_valid), W'(0));
    chk("ar_mat_c", mat_c, '0);
    chk("ar_busy", W'(busy), W'(0));
    chk("ar_overflow", W'(overflow), W'(0));
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    seen = 0;
    @(negedge CLK);
    #3 reset = 1'b1;
    issue(a_ident(), b_tens(), 0, 1, c_exp(0, 1), 0, 4);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/simd_matmul_engine.md
Name: simd_matmul_engine

Overview:
- Parametrised, handshaked successor to the fixed 4x4 SIMD matrix multiplier.
- Computes C = A x B, or C = C_prev + A x B, for signed NxN matrices.
- Uses N*N MAC lanes that iterate over the inner index k across N cycles.
- Saturates results to the output width, reports overflow, and sits between the operand fetch stage and the result writeback stage of the matrix calculator.

Parameters:
- N, 4, matrix dimension (N >= 2).
- DW, 32, signed element width of A and B.
- OW, 32, signed element width of C after saturation.
- AW, derived = 2*DW + clog2(N) + 1, internal accumulator width (localparam, not overridable).

Ports:
- CLK  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  compute advance; low freezes a COMPUTE in progress.
- in_valid  in  1  operands valid.
- in_ready  out  1  engine can accept operands.
- acc_mode  in  1  sampled at accept; 1 = accumulate onto held C, 0 = overwrite.
- mat_a  in  N*N*DW  A rows; row 0 in MSBs; within a row, element k=0 in MSBs.
- mat_b  in  N*N*DW  B columns; column 0 in MSBs; within a column, element k=0 in MSBs.
- out_valid  out  1  mat_c holds a new result.
- out_ready  in  1  consumer accepts result.
- mat_c  out  N*N*OW  column-major; element (i,j) is slot j*N+i counted from MSB (slot 0 = C(0,0) in MSBs, slot 1 = C(1,0)).
- overflow  out  1  at least one element of current mat_c saturated.
- busy  out  1  state is COMPUTE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, k=0, all accumulators=0.
  - mat_c=0, out_valid=0, overflow=0, busy=0, in_ready=1 after reset is released.
  - Reset mid-COMPUTE aborts the transaction; no result is emitted.
- States: IDLE, COMPUTE, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational, no dependence on in_valid.
- Accept = in_valid & in_ready, on an edge:
  - Latch mat_a and mat_b into operand registers; k=0; state=COMPUTE.
  - Each acc(i,j) = acc_mode ? sign-extend(mat_c(i,j)) : 0.
  - The mat_c used is the value held before that edge, including the result being handed off in the same cycle.
- COMPUTE, on each edge with enable=1:
  - acc(i,j) += A(i,k)*B(k,j), full-precision signed; k++.
  - With enable=0, k and all accumulators hold. in_valid and operand inputs are ignored.
- On the edge that performs the MAC for k=N-1:
  - mat_c(i,j) = sat_OW(final acc).
  - overflow = OR over all elements of the saturation event.
  - state=DONE, out_valid=1.
- Latency: N enabled edges from accept to out_valid high (4 for N=4, no stalls).
- Saturation:
  - Value > 2^(OW-1)-1 gives 2^(OW-1)-1.
  - Value < -2^(OW-1) gives -2^(OW-1).
  - Otherwise the low OW bits.
- DONE:
  - out_valid=1 and mat_c/overflow stable until out_ready=1.
  - On out_ready & !in_valid: state=IDLE, out_valid=0. mat_c and overflow hold their values (kept for a later acc_mode).
  - On out_ready & in_valid: simultaneous hand-off and accept; state=COMPUTE, out_valid=0 next cycle.
  - Sustained throughput is one result per N+1 cycles.
- out_valid must never drop without out_ready.
- mat_c changes only on the result edge or on reset.
- busy = (state==COMPUTE).

Test Plan:
1. Overwrite with identity, N=4, DW=OW=32, no stalls.
   - Stimulus: A = identity, B(k,j) = 10*k+j, acc_mode=0, out_ready=1.
   - Required: out_valid exactly 4 edges after accept; C(i,j) = 10*i+j; mat_c[511:480] = 0; overflow=0.
2. Accumulate onto the held result.
   - Stimulus: repeat case 1 with acc_mode=1 and the same operands.
   - Required: C(i,j) = 2*(10*i+j); C(3,3) = 66.
3. Saturation and overflow flag.
   - Stimulus: all A, B elements = 32'h7FFFFFFF.
   - Required: every C element = 32'h7FFFFFFF, overflow=1.
   - Stimulus: A all = 32'h80000000, B all = 32'h7FFFFFFF.
   - Required: every C element = 32'h80000000, overflow=1.
4. Stall.
   - Stimulus: enable=0 for 3 cycles after the 2nd MAC.
   - Required: out_valid 7 edges after accept; results identical to case 1; busy high throughout.
5. Backpressure and back-to-back accept.
   - Stimulus: hold out_ready=0 for 5 cycles in DONE.
   - Required: mat_c stable and in_ready=0 during the hold.
   - Stimulus: then assert out_ready=1 and in_valid=1 in the same cycle.
   - Required: hand-off and accept on that edge; next out_valid 4 edges later.
6. Asynchronous reset mid-compute.
   - Stimulus: drop reset between clock edges at k=2.
   - Required: immediately out_valid=0, mat_c=0, busy=0, overflow=0. After release, a new case-1 transaction completes correctly.
